// File: rtl/arb_rr_4_to_1.sv
// arb_rr_4_to_1: round-robin 4:1 arbiter feeding a one-entry registered output stage
module mux_4_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]            i_key,
  input  logic [3:0][WIDTH-1:0] i_values,
  output logic [WIDTH-1:0]      o_value
);
  // pick the value addressed by the key
  always_comb o_value = i_values[i_key];
endmodule

module arb_rr_4_to_1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [3:0]                 i_req_valid,
  input  logic [3:0][DATA_WIDTH-1:0] i_req_data,
  output logic [3:0]                 o_req_ready,
  output logic                       o_val_valid,
  input  logic                       i_val_ready,
  output logic [DATA_WIDTH-1:0]      o_val_data,
  output logic [1:0]                 o_key
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d, key_q, key_d, off, g;
  logic [3:0]            rot;
  logic [DATA_WIDTH-1:0] data_q, data_d, sel;
  logic                  load;
  mux_4_to_1 #(.WIDTH(DATA_WIDTH)) u_mux (
    .i_key   (g),
    .i_values(i_req_data),
    .o_value (sel)
  );
  // rotate valids so the pointer sits at bit 0, then take the first set bit
  always_comb begin
    rot = 4'({i_req_valid, i_req_valid} >> ptr_q);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    g = ptr_q + off;
    load = !i_rst && (state_q == EMPTY || i_val_ready) && (|i_req_valid);
    o_req_ready = load ? 4'b0001 << g : 4'b0000;
    state_d = load ? FULL : i_val_ready ? EMPTY : state_q;
    data_d = load ? sel : data_q;
    key_d = load ? g : key_q;
    ptr_d = load ? g + 2'd1 : ptr_q;
  end
  // output stage and priority pointer registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      key_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      key_q <= key_d;
      ptr_q <= ptr_d;
    end
  end
  assign o_val_valid = state_q == FULL;
  assign o_val_data = data_q;
  assign o_key = key_q;
endmodule

// File: doc/arb_rr_4_to_1.md
ARB_RR_4_TO_1 -- requirements
Module: arb_rr_4_to_1

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of each requester payload and of the output payload.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_req_valid, input, 4, per-requester valid; bit n belongs to requester n.
REQ-005 SHALL have port i_req_data, input, [3:0][DATA_WIDTH-1:0], per-requester payload.
REQ-006 SHALL have port o_req_ready, output, 4, per-requester ready; one-hot or zero.
REQ-007 SHALL have port o_val_valid, input-side-free output, 1, output payload valid.
REQ-008 SHALL have port i_val_ready, input, 1, downstream consumer ready.
REQ-009 SHALL have port o_val_data, output, DATA_WIDTH, registered selected payload.
REQ-010 SHALL have port o_key, output, 2, index of the requester whose payload is held in o_val_data.

Function
REQ-011 SHALL select the payload of the granted requester by driving the existing codebase module mux_4_to_1 with the 2-bit grant index as key and i_req_data as values.
REQ-012 SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit of i_req_valid in that order wins.
REQ-013 SHALL define load = (!o_val_valid || i_val_ready) && (|i_req_valid); grant is computed combinationally each cycle.
REQ-014 SHALL assert o_req_ready[g] only when load is 1 and g is the winning index; all other bits 0; o_req_ready may depend combinationally on i_req_valid and i_val_ready.
REQ-015 SHALL, on a load cycle, register o_val_data <= selected payload, o_key <= g, o_val_valid <= 1, ptr <= g+1 (mod 4, 3 wraps to 0).
REQ-016 SHALL, when o_val_valid=1 and i_val_ready=1 and no load, clear o_val_valid next cycle; o_val_data and o_key hold their last value.
REQ-017 SHALL, when o_val_valid=1 and i_val_ready=0, hold o_val_valid, o_val_data, o_key, ptr stable and drive o_req_ready=0.
REQ-018 SHALL implement two states: EMPTY (o_val_valid=0) and FULL (o_val_valid=1); EMPTY->FULL on load; FULL->FULL on load or stall; FULL->EMPTY on i_val_ready with no request.
REQ-019 SHALL sustain one transfer per cycle when i_val_ready is held 1 and any request is valid (drain and refill in the same cycle).
REQ-020 SHALL have latency of exactly one cycle from accept (valid&ready on requester side) to o_val_valid=1 with that payload.
REQ-021 SHALL leave ptr unchanged on cycles without load.
REQ-022 SHALL guarantee that a requester holding valid is granted within 4 load cycles (no starvation).

Reset
REQ-023 SHALL, while i_rst=1 at a clock edge, set o_val_valid=0, o_val_data=0, o_key=0, ptr=0, state EMPTY.
REQ-024 SHALL drive o_req_ready=0 in any cycle where i_rst=1.
REQ-025 SHALL discard any held payload on reset asserted mid-transfer; no transfer is reported afterward for it.

Verification
REQ-026 Reset then i_req_valid=4'b0101, i_val_ready=1 for 3 cycles -> grants 0,2,0; o_key sequence 0,2,0 one cycle after each grant; ptr 1,3,1.
REQ-027 All four valid, data n=32'h1000_000n, i_val_ready=1 for 8 cycles -> o_val_data cycles through ..0,..1,..2,..3,..0,..1,..2,..3 back-to-back, o_val_valid constant 1.
REQ-028 Load requester 3 (data 32'hDEAD_BEEF), then i_val_ready=0 for 5 cycles with i_req_valid=4'b1111 -> o_val_data stays 32'hDEAD_BEEF, o_key=3, o_req_ready=0 throughout; on i_val_ready=1 requester 0 granted (ptr wrapped 3->0).
REQ-029 Single request on requester 1, then i_req_valid=0, i_val_ready=1 -> o_val_valid high exactly one cycle, then 0; o_val_data holds payload of requester 1.
REQ-030 FULL state with i_val_ready=0, assert i_rst for one cycle -> next cycle o_val_valid=0, o_key=0, o_val_data=0; with i_req_valid=4'b1000 afterwards requester 3 granted after search from ptr 0.
REQ-031 Random valid/ready traffic, 10000 cycles -> scoreboard: every accepted payload appears once, in accept order, with matching o_key; no requester waits more than 4 load cycles.
